ram_wait: RTL and testbench
===========================

# ram_wait

Parametrised single-port synchronous RAM with a request/acknowledge handshake, programmable wait states and byte-lane write enables. Successor to the plain zero-wait RAM model: the CPU/bus side issues a read or write, the block holds it for WAIT_CYCLES clocks to model device access time, then commits it and pulses `ack`. Sits between the CPU bus interface and the memory map, and is used both as simulation memory and as an on-chip RAM with realistic timing.

## Interface

- `ADDR_BITS`, 15, address width; depth is 2^ADDR_BITS words.
- `DATA_BITS`, 8, word width; must be a multiple of 8.
- `WAIT_CYCLES`, 2, extra wait states per access; legal range 0..255.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a`  in  ADDR_BITS  word address, sampled when a request is accepted.
- `d`  in  DATA_BITS  write data, sampled when a request is accepted.
- `be`  in  DATA_BITS/8  byte-lane write enables; lane i = bits [8i+7:8i].
- `rd`  in  1  read request.
- `wr`  in  1  write request.
- `q`  out  DATA_BITS  read data, registered, held between reads.
- `busy`  out  1  high while an accepted access is in progress.
- `ack`  out  1  one-cycle pulse: access complete.

## Operation

- States: IDLE, WAIT, DONE. Reset enters IDLE.
- Accept: in IDLE or DONE, a rising edge with `rd` or `wr` high captures `a`, `d`, `be` and the operation, loads the wait counter with WAIT_CYCLES, and enters WAIT. `rd`/`wr` high in WAIT are ignored and are not queued.
- WAIT: the counter decrements each edge. At the edge where the counter is 0, the access commits, `ack` is set, and the state becomes DONE.
- DONE: lasts one cycle. Without a new request it returns to IDLE; with one it accepts as IDLE does, so back-to-back accesses are possible.
- Write commit: for each lane with captured `be[i]`=1, mem[a][lane i] <= d[lane i]. Other lanes are unchanged. `be` all zero is a legal no-op write and still acks.
- Read commit: `q` <= mem[a] as captured. A read issued after a committed write to the same address returns the new data.
- `rd` and `wr` both high at accept: treated as a write. `q` is unchanged.
- `q` changes only at a read commit. It holds its value through writes and idle periods.
- Memory contents are not initialised or cleared by reset.
- Reset mid-access aborts the access. No memory write occurs, and `q` is cleared.

## Timing

- Reset values: `q`=0, `busy`=0, `ack`=0, state IDLE, counter 0.
- Request accepted at edge k, with N = WAIT_CYCLES:
  - `busy` is 1 from edge k.
  - The access commits at edge k+N+1. At that edge `ack` goes 1, `busy` goes 0, and `q` is valid for reads.
  - `ack` returns to 0 at edge k+N+2 unless that edge completes another access, which cannot happen for N≥0.
- With N=0 the access takes 2 cycles from request to `ack`.
- Maximum throughput is one access per N+2 cycles. The next request may be presented during the `ack` cycle.
- `ack` and `busy` are never high together.
- Counter is 8 bits wide. WAIT_CYCLES=0 skips the countdown, so the commit happens at the first edge in WAIT.
- Inputs `a`, `d`, `be` may change freely after the accept edge.

## Test plan

- Reset, then write 0xA5 to address 0x0010 with N=2, then read 0x0010. The write's `ack` comes 3 edges after accept. The read returns `q`=0xA5 with `ack` 3 edges after its accept. `busy` is high for exactly 3 cycles per access.
- DATA_BITS=16. Write 0x1234 with be=11, then write 0xABCD with be=01 to the same address, then read. Required result: `q`=0x12CD.
- N=0, back-to-back: assert `rd` during each `ack` cycle for addresses 0..3, each pre-loaded with value = address. Required: an `ack` every 2 cycles, with `q` = 0,1,2,3 in order.
- Pulse `rd`/`wr` while `busy`=1. Required: no extra `ack`, memory unchanged, and the original access completes on schedule.
- Accept a write of 0x5A to 0x0020 (previously 0x11) with N=4. Drop `rst_n` at cycle 2, then release it. Required: `q`=0, `busy`=0, `ack`=0 immediately, and a subsequent read of 0x0020 returns 0x11.
- `rd`=`wr`=1 with d=0x77 at 0x0030, after a prior read that left `q`=0x42. Required: `ack` after N+1 edges, `q` stays 0x42, and a later read of 0x0030 returns 0x77.

Source files
------------

// File: rtl/ram_wait.sv
// Single-port synchronous RAM with programmable wait states,
// byte-lane write enables and a busy/ack completion handshake.
module ram_wait #(
  parameter int ADDR_BITS   = 15,
  parameter int DATA_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_BITS-1:0]   a,
  input  logic [DATA_BITS-1:0]   d,
  input  logic [DATA_BITS/8-1:0] be,
  input  logic                   rd,
  input  logic                   wr,
  output logic [DATA_BITS-1:0]   q,
  output logic                   busy,
  output logic                   ack
);

  localparam int LANES = DATA_BITS / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [7:0]           cnt;
  logic                 op_wr;
  logic [ADDR_BITS-1:0] a_r;
  logic [DATA_BITS-1:0] d_r;
  logic [LANES-1:0]     be_r;
  logic                 req;
  logic                 accept;
  logic                 commit;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  assign req    = rd | wr;
  assign accept = req && (state != WAIT);
  assign commit = (state == WAIT) && (cnt == 8'd0);
  assign busy   = (state == WAIT);
  assign ack    = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (req) state_n = WAIT;
      WAIT: if (cnt == 8'd0) state_n = DONE;
      DONE: state_n = req ? WAIT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      op_wr <= 1'b0;
      a_r   <= '0;
      d_r   <= '0;
      be_r  <= '0;
      q     <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt   <= 8'(WAIT_CYCLES);
        op_wr <= wr;
        a_r   <= a;
        d_r   <= d;
        be_r  <= be;
      end else if (busy && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (commit && !op_wr) q <= mem[a_r];
    end
  end

  // Contents are deliberately not reset; an aborted access never commits.
  always_ff @(posedge clk) begin
    if (commit && op_wr) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_r[i]) mem[a_r][8*i +: 8] <= d_r[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ram_wait.sv
// Directed bench for ram_wait: vector table on a 16-bit N=2 instance,
// plus N=0 back-to-back and reset-abort sequences.
module tb_ram_wait;

  localparam int N0 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  a0 = '0;
  logic [15:0] d0 = '0;
  logic [1:0]  be0 = '0;
  logic        rd0 = 1'b0;
  logic        wr0 = 1'b0;
  logic [15:0] q0;
  logic        busy0;
  logic        ack0;

  logic [7:0]  a1 = '0;
  logic [7:0]  d1 = '0;
  logic [0:0]  be1 = '0;
  logic        rd1 = 1'b0;
  logic        wr1 = 1'b0;
  logic [7:0]  q1;
  logic        busy1;
  logic        ack1;

  int errors = 0;
  int checks = 0;

  ram_wait #(.ADDR_BITS(8), .DATA_BITS(16), .WAIT_CYCLES(N0)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a0), .d(d0), .be(be0),
    .rd(rd0), .wr(wr0), .q(q0), .busy(busy0), .ack(ack0)
  );

  ram_wait #(.ADDR_BITS(8), .DATA_BITS(8), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .d(d1), .be(be1),
    .rd(rd1), .wr(wr1), .q(q1), .busy(busy1), .ack(ack1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        pulse;
    logic [7:0]  a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [15:0] exp_q;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one access on u0 and follow it to completion.
  task automatic access0(input vec_t v, input int idx);
    int n;
    int nb;
    rd0 = v.rd;
    wr0 = v.wr;
    a0  = v.a;
    d0  = v.d;
    be0 = v.be;
    n   = 0;
    nb  = 0;
    while (n < 20) begin
      step();
      n++;
      rd0 = v.pulse;
      wr0 = v.pulse;
      a0  = 8'h41;
      d0  = 16'hDEAD;
      be0 = 2'b11;
      if (ack0) break;
      if (busy0) nb++;
    end
    rd0 = 1'b0;
    wr0 = 1'b0;
    chk($sformatf("latency[%0d]", idx), 32'(n), 32'(N0 + 2));
    chk($sformatf("busy_cycles[%0d]", idx), 32'(nb), 32'(N0 + 1));
    chk($sformatf("busy_at_ack[%0d]", idx), 32'(busy0), 32'd0);
    chk($sformatf("q[%0d]", idx), 32'(q0), 32'(v.exp_q));
    step();
    chk($sformatf("ack_drop[%0d]", idx), 32'(ack0), 32'd0);
    chk($sformatf("idle_busy[%0d]", idx), 32'(busy0), 32'd0);
  endtask

  vec_t tbl[20];
  vec_t rv;

  initial begin
    tbl[0]  = '{0, 1, 0, 8'h10, 16'h00A5, 2'b11, 16'h0000};
    tbl[1]  = '{1, 0, 0, 8'h10, 16'h0000, 2'b00, 16'h00A5};
    tbl[2]  = '{0, 1, 0, 8'h11, 16'h1234, 2'b11, 16'h00A5};
    tbl[3]  = '{0, 1, 0, 8'h11, 16'hABCD, 2'b01, 16'h00A5};
    tbl[4]  = '{1, 0, 0, 8'h11, 16'h0000, 2'b00, 16'h12CD};
    tbl[5]  = '{0, 1, 0, 8'h12, 16'hFFFF, 2'b11, 16'h12CD};
    tbl[6]  = '{0, 1, 0, 8'h12, 16'h0000, 2'b00, 16'h12CD};
    tbl[7]  = '{1, 0, 0, 8'h12, 16'h0000, 2'b00, 16'hFFFF};
    tbl[8]  = '{0, 1, 0, 8'h13, 16'h0000, 2'b11, 16'hFFFF};
    tbl[9]  = '{0, 1, 0, 8'h13, 16'h5555, 2'b10, 16'hFFFF};
    tbl[10] = '{1, 0, 0, 8'h13, 16'h0000, 2'b00, 16'h5500};
    tbl[11] = '{0, 1, 0, 8'h31, 16'h0042, 2'b11, 16'h5500};
    tbl[12] = '{1, 0, 0, 8'h31, 16'h0000, 2'b00, 16'h0042};
    tbl[13] = '{1, 1, 0, 8'h30, 16'h0077, 2'b11, 16'h0042};
    tbl[14] = '{1, 0, 0, 8'h30, 16'h0000, 2'b00, 16'h0077};
    tbl[15] = '{0, 1, 0, 8'h20, 16'h0011, 2'b11, 16'h0077};
    tbl[16] = '{0, 1, 0, 8'h40, 16'h1111, 2'b11, 16'h0077};
    tbl[17] = '{0, 1, 0, 8'h41, 16'h2222, 2'b11, 16'h0077};
    tbl[18] = '{1, 0, 1, 8'h40, 16'h0000, 2'b00, 16'h1111};
    tbl[19] = '{1, 0, 0, 8'h41, 16'h0000, 2'b00, 16'h2222};

    repeat (2) step();
    chk("rst_q", 32'(q0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ack", 32'(ack0), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) access0(tbl[i], i);

    // Reset partway through a write must abort it.
    rv = '{1, 0, 0, 8'h10, 16'h0000, 2'b00, 16'h00A5};
    access0(rv, 20);
    wr0 = 1'b1;
    a0  = 8'h20;
    d0  = 16'h005A;
    be0 = 2'b11;
    step();
    wr0 = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(q0), 32'd0);
    chk("abort_busy0", 32'(busy0), 32'd0);
    chk("abort_ack", 32'(ack0), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    rv = '{1, 0, 0, 8'h20, 16'h0000, 2'b00, 16'h0011};
    access0(rv, 21);

    // N=0: preload 0..3, then stream reads presented in each ack cycle.
    for (int i = 0; i < 4; i++) begin
      a1  = 8'(i);
      d1  = 8'(i);
      be1 = 1'b1;
      wr1 = 1'b1;
      step();
      wr1 = 1'b0;
      step();
      chk($sformatf("n0_wack[%0d]", i), 32'(ack1), 32'd1);
      step();
    end
    rd1 = 1'b1;
    a1  = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("n0_busy[%0d]", i), 32'({busy1, ack1}), 32'b10);
      step();
      chk($sformatf("n0_ack[%0d]", i), 32'({busy1, ack1}), 32'b01);
      chk($sformatf("n0_q[%0d]", i), 32'(q1), 32'(i));
      a1 = 8'(i + 1);
      if (i == 3) rd1 = 1'b0;
    end
    step();
    chk("n0_end", 32'({busy1, ack1}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
